// File: rtl/butterfly_sched_pkg.sv
// Shared Kyber butterfly scheduler definitions: op codes, FSM encoding,
// stage counts, ROM/RAM base offsets and the INTT stage map.
package butterfly_sched_pkg;

    localparam logic [1:0] OP_NTT    = 2'd0;
    localparam logic [1:0] OP_INTT   = 2'd1;
    localparam logic [1:0] OP_MULT   = 2'd2;
    localparam logic [1:0] OP_ADDSUB = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Stages 0..PAIR_STAGES-1 work on (j, j+d) pairs; the rest walk words in order.
    localparam logic [2:0] PAIR_STAGES = 3'd5;
    localparam logic [2:0] LAST_STAGE  = 3'd6;
    localparam logic [4:0] LAST_WORD   = 5'd31;

    // Last per-word phase of the MULT (6-cycle) and ADDSUB (4-cycle) sequences.
    localparam logic [2:0] MULT_LAST_PH   = 3'd5;
    localparam logic [2:0] ADDSUB_LAST_PH = 3'd3;

    localparam logic [6:0] COEF_BASE_WORD = 7'd32;
    localparam logic [6:0] COEF_BASE_MULT = 7'd64;
    localparam logic [5:0] POLY_B_BASE    = 6'd32;

    typedef struct packed {
        logic       vld;
        logic [4:0] addr;
    } wb_entry_t;

    // INTT runs the NTT stage tags in reverse order.
    function automatic logic [2:0] stage_map(input logic [1:0] op, input logic [2:0] idx);
        return (op == OP_INTT) ? (LAST_STAGE - idx) : idx;
    endfunction

endpackage

// File: rtl/butterfly_sched_if.sv
// Request/datapath-control bundle between the requester and the scheduler.
// bf_type carries the per-cycle pair/sub tag ("type" is a reserved word).
interface butterfly_sched_if;
    logic       start;
    logic [1:0] op;
    logic       sub;
    logic [1:0] mode;
    logic [2:0] stage;
    logic       bf_type;
    logic       pre_load;
    logic       load;
    logic [5:0] raddr;
    logic [6:0] coef_addr;
    logic       we;
    logic [4:0] waddr;
    logic       busy;
    logic       done;

    modport master (
        output start, op, sub,
        input  mode, stage, bf_type, pre_load, load, raddr, coef_addr,
               we, waddr, busy, done
    );

    modport slave (
        input  start, op, sub,
        output mode, stage, bf_type, pre_load, load, raddr, coef_addr,
               we, waddr, busy, done
    );
endinterface

// File: rtl/butterfly_sched_wb_delay.sv
// Write-back delay line: (valid, addr) pairs shift toward a run-time tap
// selected by the active op latency; we/waddr come from the tap.
module wb_delay
    import butterfly_sched_pkg::*;
#(
    parameter int DEPTH = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [4:0] push_addr,
    input  logic [7:0] lat,
    output logic       we,
    output logic [4:0] waddr,
    output logic       pending
);

    wb_entry_t line [DEPTH];

    // Shift toward the tap; slots at/after the tap are emptied so a short-latency
    // op never leaves entries that a later long-latency op would see.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) line[k] <= '0;
        end else begin
            line[0] <= wb_entry_t'{vld: push, addr: (push ? push_addr : 5'd0)};
            for (int k = 1; k < DEPTH; k++)
                line[k] <= (8'(k) < lat) ? line[k-1] : '0;
        end
    end

    // Tap select plus "write still to come" flag for the FSM drain check.
    always_comb begin
        we      = 1'b0;
        waddr   = '0;
        pending = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (8'(k) + 8'd1 == lat) begin
                we    = line[k].vld;
                waddr = line[k].vld ? line[k].addr : 5'd0;
            end
            if (8'(k) + 8'd1 < lat) pending = pending | line[k].vld;
        end
    end

endmodule

// File: rtl/butterfly_sched.sv
// Kyber butterfly scheduler: sequences RAM reads, twiddle addresses and
// datapath tags for NTT/INTT/MULT/ADDSUB and schedules the write-backs.
module butterfly_sched
    import butterfly_sched_pkg::*;
#(
    parameter int LAT_NTT    = 7,
    parameter int LAT_MULT   = 11,
    parameter int LAT_ADDSUB = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    butterfly_sched_if.slave bus
);

    localparam int MAX_NM = (LAT_NTT > LAT_MULT) ? LAT_NTT : LAT_MULT;
    localparam int WB_DEPTH = (MAX_NM > LAT_ADDSUB) ? MAX_NM : LAT_ADDSUB;

    logic [1:0] state;
    logic [1:0] mode_q;
    logic       sub_q;
    logic [2:0] si;
    logic [2:0] ph;
    logic [4:0] cnt;

    logic       is_ntt, is_mult, last_ph, push, pending;
    logic [2:0] st;
    logic [7:0] lat;
    logic [4:0] d, pidx, grp, off, j;

    assign is_ntt  = ~mode_q[1];
    assign is_mult = (mode_q == OP_MULT);
    assign st      = stage_map(mode_q, si);
    assign last_ph = is_mult ? (ph == MULT_LAST_PH) : (ph == ADDSUB_LAST_PH);
    assign lat     = is_ntt ? 8'(LAT_NTT) : (is_mult ? 8'(LAT_MULT) : 8'(LAT_ADDSUB));
    assign push    = (state == ST_ISSUE) && (is_ntt || last_ph);

    // Pair addressing: pair p splits into group p/d and offset p%d,
    // so j = group*2d + offset and the partner word is j + d (bit d of j is 0).
    assign d    = 5'd16 >> st;
    assign pidx = {1'b0, cnt[4:1]};
    assign grp  = pidx >> (3'd4 - st);
    assign off  = pidx & (d - 5'd1);
    assign j    = (grp << (3'd5 - st)) | off;

    assign bus.mode = mode_q;
    assign bus.busy = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign bus.done = (state == ST_DONE);

    // Control FSM and issue counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= OP_NTT;
            sub_q  <= 1'b0;
            si     <= '0;
            ph     <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    state  <= ST_ISSUE;
                    mode_q <= bus.op;
                    sub_q  <= bus.sub;
                    si     <= '0;
                    ph     <= '0;
                    cnt    <= '0;
                end
                ST_ISSUE: begin
                    if (is_ntt || last_ph) begin
                        ph  <= '0;
                        cnt <= cnt + 5'd1;
                        if (cnt == LAST_WORD) state <= ST_DRAIN;
                    end else begin
                        ph <= ph + 3'd1;
                    end
                end
                // The tap write happens in the cycle pending drops, so the next
                // stage's first read lands one cycle after the last write.
                ST_DRAIN: if (!pending) begin
                    if (is_ntt && si != LAST_STAGE) begin
                        si    <= si + 3'd1;
                        state <= ST_ISSUE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-cycle datapath tags and read/twiddle addresses; all zero outside ISSUE.
    always_comb begin
        bus.stage     = '0;
        bus.bf_type   = 1'b0;
        bus.pre_load  = 1'b0;
        bus.load      = 1'b0;
        bus.raddr     = '0;
        bus.coef_addr = '0;
        if (state == ST_ISSUE) begin
            if (is_ntt) begin
                bus.stage = st;
                if (st < PAIR_STAGES) begin
                    bus.raddr     = {1'b0, (cnt[0] ? (j | d) : j)};
                    bus.bf_type   = cnt[0];
                    bus.coef_addr = (7'd1 << st) + {2'b0, grp};
                end else begin
                    bus.raddr     = {1'b0, cnt};
                    bus.coef_addr = COEF_BASE_WORD + {2'b0, cnt};
                end
            end else begin
                bus.bf_type = is_mult ? 1'b0 : sub_q;
                if (is_mult) bus.coef_addr = COEF_BASE_MULT + {2'b0, cnt};
                case (ph)
                    3'd0: begin
                        bus.raddr    = {1'b0, cnt};
                        bus.pre_load = 1'b1;
                    end
                    3'd1: begin
                        bus.raddr = POLY_B_BASE | {1'b0, cnt};
                        bus.load  = 1'b1;
                    end
                    // MULT phases 2..5 -> stages 2,3,0,1; ADDSUB phases 2,3 -> 0,1.
                    default: bus.stage = is_mult ? {1'b0, ph[1:0]} : {2'b0, ph[0]};
                endcase
            end
        end
    end

    wb_delay #(.DEPTH(WB_DEPTH)) u_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (is_ntt ? bus.raddr[4:0] : cnt),
        .lat       (lat),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .pending   (pending)
    );

endmodule

// File: tb/tb_butterfly_sched.sv
// Bench for butterfly_sched: randomized op sequence compared cycle by cycle
// against a trace built from the Kyber loop structure and the latency rules.
`timescale 1ns/1ps
module tb_butterfly_sched;
    import butterfly_sched_pkg::*;

    localparam int LAT_NTT    = 7;
    localparam int LAT_MULT   = 11;
    localparam int LAT_ADDSUB = 3;
    localparam int MAXC       = 400;

    typedef struct packed {
        logic [2:0] pad;
        logic       busy;
        logic       done;
        logic       we;
        logic [4:0] waddr;
        logic [2:0] stage;
        logic       typ;
        logic       pre_load;
        logic       load;
        logic [5:0] raddr;
        logic [6:0] coef;
        logic [1:0] mode;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    butterfly_sched_if bus();

    butterfly_sched #(.LAT_NTT(LAT_NTT), .LAT_MULT(LAT_MULT), .LAT_ADDSUB(LAT_ADDSUB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    obs_t       exp_tr [MAXC];
    int         t, lastw, nwr;
    logic [1:0] last_mode = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o          = '0;
        o.busy     = bus.busy;
        o.done     = bus.done;
        o.we       = bus.we;
        o.waddr    = bus.waddr;
        o.stage    = bus.stage;
        o.typ      = bus.bf_type;
        o.pre_load = bus.pre_load;
        o.load     = bus.load;
        o.raddr    = bus.raddr;
        o.coef     = bus.coef_addr;
        o.mode     = bus.mode;
        return o;
    endfunction

    // One issue cycle of the reference trace.
    task automatic put(input int s, input logic ty, input logic pl, input logic ld,
                       input int ra, input int ca);
        exp_tr[t].stage    = 3'(s);
        exp_tr[t].typ      = ty;
        exp_tr[t].pre_load = pl;
        exp_tr[t].load     = ld;
        exp_tr[t].raddr    = 6'(ra);
        exp_tr[t].coef     = 7'(ca);
        t++;
    endtask

    task automatic wr(input int at, input int a);
        exp_tr[at].we    = 1'b1;
        exp_tr[at].waddr = 5'(a);
        nwr++;
        if (at > lastw) lastw = at;
    endtask

    // Reference trace; cycle 0 is the first cycle after start is accepted.
    task automatic model(input logic [1:0] o, input logic sb);
        logic ty;
        for (int c = 0; c < MAXC; c++) begin
            exp_tr[c]      = '0;
            exp_tr[c].mode = o;
        end
        t = 0; lastw = 0; nwr = 0;
        ty = (o == OP_ADDSUB) ? sb : 1'b0;
        if (o == OP_NTT || o == OP_INTT) begin
            for (int si = 0; si < 7; si++) begin
                int s, d, k;
                s = (o == OP_INTT) ? 6 - si : si;
                if (s < 5) begin
                    d = 16 >> s;
                    k = 1 << s;
                    for (int base = 0; base < 32; base += 2 * d) begin
                        for (int jj = base; jj < base + d; jj++) begin
                            wr(t + LAT_NTT, jj);     put(s, 1'b0, 1'b0, 1'b0, jj, k);
                            wr(t + LAT_NTT, jj + d); put(s, 1'b1, 1'b0, 1'b0, jj + d, k);
                        end
                        k++;
                    end
                end else begin
                    for (int w = 0; w < 32; w++) begin
                        wr(t + LAT_NTT, w); put(s, 1'b0, 1'b0, 1'b0, w, 32 + w);
                    end
                end
                t = lastw + 1;
            end
        end else if (o == OP_MULT) begin
            for (int w = 0; w < 32; w++) begin
                put(0, ty, 1'b1, 1'b0, w, 64 + w);
                put(0, ty, 1'b0, 1'b1, 32 + w, 64 + w);
                put(2, ty, 1'b0, 1'b0, 0, 64 + w);
                put(3, ty, 1'b0, 1'b0, 0, 64 + w);
                put(0, ty, 1'b0, 1'b0, 0, 64 + w);
                wr(t + LAT_MULT, w);
                put(1, ty, 1'b0, 1'b0, 0, 64 + w);
            end
        end else begin
            for (int w = 0; w < 32; w++) begin
                put(0, ty, 1'b1, 1'b0, w, 0);
                put(0, ty, 1'b0, 1'b1, 32 + w, 0);
                put(0, ty, 1'b0, 1'b0, 0, 0);
                wr(t + LAT_ADDSUB, w);
                put(1, ty, 1'b0, 1'b0, 0, 0);
            end
        end
        for (int c = 0; c <= lastw; c++) exp_tr[c].busy = 1'b1;
        exp_tr[lastw + 1].done = 1'b1;
    endtask

    // Launch one op and compare every cycle; noise pulses start while busy.
    task automatic run_op(input logic [1:0] o, input logic sb, input bit noise, input string nm);
        obs_t cur, idle;
        int   nwe, done_at;
        model(o, sb);
        @(negedge clk);
        idle = '0;
        idle.mode = last_mode;
        chk({nm, "_idle"}, sample(), idle);
        bus.start = 1'b1; bus.op = o; bus.sub = sb;
        @(negedge clk);
        bus.start = 1'b0;
        nwe = 0; done_at = -1;
        for (int c = 0; c <= lastw + 3; c++) begin
            cur = sample();
            chk($sformatf("%s_c%0d", nm, c), cur, exp_tr[c]);
            if (cur.we) nwe++;
            if (cur.done && done_at < 0) done_at = c;
            if (noise && c <= lastw) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.op    = 2'($urandom);
                bus.sub   = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, "_nwe"}, nwe, (o == OP_NTT || o == OP_INTT) ? 224 : 32);
        chk({nm, "_done_at"}, done_at, lastw + 1);
        last_mode = o;
    endtask

    // Abort an NTT in stage 3 with an asynchronous reset.
    task automatic rst_mid();
        obs_t cur;
        model(OP_NTT, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_NTT; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 125; c++) begin
            chk($sformatf("pre_rst_c%0d", c), sample(), exp_tr[c]);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        cur = sample();
        chk("rst_mid_we", cur.we, 1'b0);
        chk("rst_mid_busy", cur.busy, 1'b0);
        chk("rst_mid_all", cur, '0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_hold", sample(), '0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_idle", sample(), '0);
        end
        last_mode = 2'd0;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'd0; bus.sub = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", sample(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_NTT,    1'b0, 1'b0, "ntt");
        run_op(OP_MULT,   1'b0, 1'b0, "mult");
        run_op(OP_ADDSUB, 1'b1, 1'b0, "addsub1");
        run_op(OP_INTT,   1'b0, 1'b1, "intt_busy");
        run_op(OP_ADDSUB, 1'b0, 1'b1, "addsub0_busy");
        run_op(OP_MULT,   1'b0, 1'b1, "mult_busy");
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        rst_mid();
        run_op(OP_NTT, 1'b0, 1'b0, "ntt_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/butterfly_sched.md
BUTTERFLY_SCHED -- requirements
Module: butterfly_sched

Interface
REQ-001 SHALL have parameter LAT_NTT, default 7: cycles from a read issue to its write-back in NTT/INTT.
REQ-002 SHALL have parameter LAT_MULT, default 11: cycles from a quarter-1 issue to its write-back in MULT.
REQ-003 SHALL have parameter LAT_ADDSUB, default 3: cycles from a stage-1 issue to its write-back in ADDSUB.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port start, input, 1 bit: one-cycle operation request.
REQ-008 Port op, input, 2 bits: 0 NTT, 1 INTT, 2 MULT, 3 ADDSUB; sampled with start.
REQ-009 Port sub, input, 1 bit: ADDSUB subtract select; sampled with start.
REQ-010 Port mode, output, 2 bits: latched op, driven to the butterfly datapath.
REQ-011 Port stage, output, 3 bits: per-cycle stage tag to the datapath.
REQ-012 Port type, output, 1 bit: per-cycle pair/sub tag to the datapath.
REQ-013 Port pre_load, output, 1 bit: datapath A-buffer pre-load strobe.
REQ-014 Port load, output, 1 bit: datapath A/B buffer load strobe.
REQ-015 Port raddr, output, 6 bits: polynomial RAM read word address; bit 5 selects poly A (0) or poly B (1).
REQ-016 Port coef_addr, output, 7 bits: twiddle ROM address.
REQ-017 Port we, output, 1 bit: RAM write enable for datapath out_data.
REQ-018 Port waddr, output, 5 bits: write word address, always in poly A.
REQ-019 Port busy, output, 1 bit: high from the cycle after accepted start until done.
REQ-020 Port done, output, 1 bit: one-cycle pulse after the final write.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; start is accepted only in IDLE, otherwise ignored.
REQ-022 IDLE->ISSUE on start; ISSUE->DRAIN after the last issue of a stage (NTT/INTT) or operation; DRAIN->ISSUE (next stage) or DONE when no write is outstanding; DONE->IDLE after one cycle.
REQ-023 NTT SHALL run stages 0..6; INTT SHALL run stages 0..6 with stage = 6 - stage index mapping fixed in the package.
REQ-024 NTT/INTT stages 0-4 SHALL issue 32 reads as pairs (j, j+d), d = 16>>s words, with type=0 then type=1, one read per cycle.
REQ-025 NTT/INTT stages 5-6 SHALL issue words 0..31 in order with type=0.
REQ-026 coef_addr SHALL equal the Kyber zeta index 2^s + (pair index / d) for stages 0-4, and 32 + word index for stages 5-6; it is valid in the issue cycle.
REQ-027 NTT/INTT we SHALL assert exactly LAT_NTT cycles after each issue, with waddr equal to that issue's raddr[4:0].
REQ-028 The next stage SHALL not issue before the previous stage's last write (RAW hazard).
REQ-029 MULT per word w SHALL take 6 cycles: raddr=w with pre_load, raddr=32+w with load, then stage 2,3,0,1; coef_addr = 64 + w.
REQ-030 MULT we SHALL assert LAT_MULT cycles after the stage-1 cycle, with waddr=w.
REQ-031 ADDSUB per word SHALL take 4 cycles: A read with pre_load, B read with load, then stage 0, stage 1; type = latched sub throughout.
REQ-032 ADDSUB we SHALL assert LAT_ADDSUB cycles after the stage-1 cycle.
REQ-033 Outstanding writes SHALL be tracked by a delay line of (valid, addr), depth equal to the largest LAT parameter.
REQ-034 Idle outputs SHALL be pre_load=load=we=0, stage=0, type=0, raddr=0, coef_addr=0.

Reset
REQ-035 rst_n low SHALL force IDLE, clear the delay line and drive every output to 0 asynchronously.
REQ-036 Reset mid-operation SHALL abort it with no further we and no done pulse.

Structure
REQ-037 Op encodings, FSM state encoding, stage counts, the INTT stage map and ROM base offsets (32, 64) SHALL live in the shared kyber package.
REQ-038 The write-back delay line SHALL be one sub-module, wb_delay.

Verification
REQ-039 NTT: start, op=0 -> 224 reads; first we at cycle issue+7 with waddr=0; done in total = 7*(32+7)+overhead cycles; coef_addr=1 for stage-0 pair 0.
REQ-040 MULT: start, op=2 -> per word: raddr 0 then 32, stage sequence 2,3,0,1; we for waddr=0 at 11 cycles after stage 1; 32 writes.
REQ-041 ADDSUB: op=3, sub=1 -> type=1 on every issue cycle; 32 writes to waddr 0..31 in order.
REQ-042 Start asserted while busy -> ignored; the running op completes with unchanged counts.
REQ-043 rst_n low during NTT stage 3 -> we=0 and busy=0 immediately; a later start runs a full NTT.
REQ-044 Stage boundary: last write of stage s precedes the first read of stage s+1 by at least one cycle.
